// File: rtl/switch2x2_queued_pkg.sv
// Packet field layout macros and shared types for the queued 2x2 switch.
// Forward packets: [15:14] priority, [13:11] core id, [10:0] payload; backward packets are 12 bits wide.
`ifndef SWITCH2X2_TYPES_VH
`define SWITCH2X2_TYPES_VH
`define N                  8
`define CORE_ID_BITS       3
`define PACKET_W           16
`define PKT_PRI_MSB        15
`define PKT_PRI_LSB        14
`define PKT_CORE_MSB       13
`define PKT_CORE_LSB       11
`define PKT_PRIORITY(p)    p[`PKT_PRI_MSB:`PKT_PRI_LSB]
`define PKT_CORE_ID(p)     p[`PKT_CORE_MSB:`PKT_CORE_LSB]
`define BACK_PACKET_W      12
`define BACK_PKT_PRI_MSB   11
`define BACK_PKT_PRI_LSB   10
`define BACK_PKT_CORE_MSB  9
`define BACK_PKT_CORE_LSB  7
`define BACK_PKT_PRIORITY(p) p[`BACK_PKT_PRI_MSB:`BACK_PKT_PRI_LSB]
`define BACK_PKT_CORE_ID(p)  p[`BACK_PKT_CORE_MSB:`BACK_PKT_CORE_LSB]
`endif

package switch2x2_queued_pkg;

    localparam int PRI_W = 2;

    typedef logic [PRI_W-1:0] pri_t;

    localparam pri_t PRI_MAX = 2'd3;

    // Which inputs target a given output port this cycle, encoded {a, b}.
    typedef enum logic [1:0] {
        ARB_NONE   = 2'b00,
        ARB_B_ONLY = 2'b01,
        ARB_A_ONLY = 2'b10,
        ARB_BOTH   = 2'b11
    } arb_e;

    function automatic pri_t bump_pri(input pri_t pri);
        return (pri == PRI_MAX) ? PRI_MAX : pri + 2'd1;
    endfunction

endpackage

// File: rtl/switch_port_fifo.sv
// Output-port queue: two writes (slot 0 then slot 1) and one read per cycle.
// The head is forced to zero whenever the queue is empty.
module switch_port_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr0_en,
    input  logic [W-1:0]               wr0_data,
    input  logic                       wr1_en,
    input  logic [W-1:0]               wr1_data,
    input  logic                       rd_en,
    output logic [W-1:0]               head,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] occ
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [OW-1:0] occ_r;
    logic [1:0]    n_push_s;
    logic          pop_s;

    assign n_push_s = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign pop_s    = rd_en && (occ_r != {OW{1'b0}});

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= {OW{1'b0}};
        end else begin
            if (wr0_en) begin
                mem_r[wr_ptr_r] <= wr0_data;
            end
            // A lone slot-1 write still lands at the current write pointer.
            if (wr1_en) begin
                mem_r[wr0_en ? wr_ptr_r + AW'(1'b1) : wr_ptr_r] <= wr1_data;
            end
            wr_ptr_r <= wr_ptr_r + AW'(n_push_s);
            rd_ptr_r <= rd_ptr_r + AW'(pop_s);
            occ_r    <= occ_r + OW'(n_push_s) - OW'(pop_s);
        end
    end

    assign head  = (occ_r != {OW{1'b0}}) ? mem_r[rd_ptr_r] : {W{1'b0}};
    assign valid = (occ_r != {OW{1'b0}});
    assign occ   = occ_r;

endmodule

// File: rtl/switch2x2_queued.sv
// 2x2 switch element with one queue per output port; same-port contention is
// resolved by priority, the loser gets a priority bump, overflow is dropped and counted.
module switch2x2_queued
    import switch2x2_queued_pkg::*;
#(
    parameter int WIR_W = `PACKET_W,
    parameter int DEPTH = 4,
    parameter int N     = `N,
    parameter int STAGE = 0,
    parameter int INDEX = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIR_W-1:0]           a,
    input  logic [WIR_W-1:0]           b,
    input  logic                       va,
    input  logic                       vb,
    input  logic                       sel_a,
    input  logic                       sel_b,
    input  logic                       rdy0,
    input  logic                       rdy1,
    output logic [WIR_W-1:0]           y0,
    output logic [WIR_W-1:0]           y1,
    output logic                       v0,
    output logic                       v1,
    output logic [$clog2(DEPTH+1)-1:0] occ0,
    output logic [$clog2(DEPTH+1)-1:0] occ1,
    output logic [N-1:0]               dropped_core_vector,
    output logic                       collision_detected,
    output logic [15:0]                drop_cnt
);
    localparam bit IS_BACKWARD = (WIR_W != `PACKET_W);
    localparam int OW          = $clog2(DEPTH + 1);
    localparam int CW          = `CORE_ID_BITS;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STAGE < 0 || INDEX < 0) begin : g_bad_param
        $error("switch2x2_queued: illegal DEPTH/STAGE/INDEX");
    end

    pri_t             pri_a_s, pri_b_s;
    logic [CW-1:0]    core_a_s, core_b_s;
    logic [WIR_W-1:0] bump_a_s, bump_b_s;
    logic             a_wins_s;

    logic [1:0]       rdy_s, valid_s, pop_s;
    logic [1:0]       cand_a_s, cand_b_s, drop_a_s, drop_b_s;
    logic [1:0]       wr0_en_s, wr1_en_s;
    logic [WIR_W-1:0] wr0_data_s [2];
    logic [WIR_W-1:0] wr1_data_s [2];
    logic [WIR_W-1:0] head_s     [2];
    logic [OW-1:0]    occ_s      [2];
    logic [OW:0]      free_s     [2];
    arb_e             arb_s      [2];

    logic [N-1:0]     drop_vec_s;
    logic [1:0]       n_drop_s;
    logic [16:0]      cnt_sum_s;
    logic [N-1:0]     dropped_r;
    logic             coll_r;
    logic [15:0]      drop_cnt_r;

    if (!IS_BACKWARD) begin : g_fwd
        // Field extraction and loser rewrite for the forward packet layout.
        always_comb begin
            pri_a_s  = `PKT_PRIORITY(a);
            pri_b_s  = `PKT_PRIORITY(b);
            core_a_s = `PKT_CORE_ID(a);
            core_b_s = `PKT_CORE_ID(b);
            bump_a_s = a;
            bump_b_s = b;
            bump_a_s[`PKT_PRI_MSB:`PKT_PRI_LSB] = bump_pri(`PKT_PRIORITY(a));
            bump_b_s[`PKT_PRI_MSB:`PKT_PRI_LSB] = bump_pri(`PKT_PRIORITY(b));
        end
    end else begin : g_back
        // Field extraction and loser rewrite for the backward packet layout.
        always_comb begin
            pri_a_s  = `BACK_PKT_PRIORITY(a);
            pri_b_s  = `BACK_PKT_PRIORITY(b);
            core_a_s = `BACK_PKT_CORE_ID(a);
            core_b_s = `BACK_PKT_CORE_ID(b);
            bump_a_s = a;
            bump_b_s = b;
            bump_a_s[`BACK_PKT_PRI_MSB:`BACK_PKT_PRI_LSB] = bump_pri(`BACK_PKT_PRIORITY(a));
            bump_b_s[`BACK_PKT_PRI_MSB:`BACK_PKT_PRI_LSB] = bump_pri(`BACK_PKT_PRIORITY(b));
        end
    end

    assign a_wins_s = (pri_a_s >= pri_b_s);
    assign rdy_s    = {rdy1, rdy0};

    // Per-port admission: winner takes slot 0, loser slot 1, and free space decides who gets in.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            cand_a_s[p]   = va && (sel_a == p[0]);
            cand_b_s[p]   = vb && (sel_b == p[0]);
            pop_s[p]      = valid_s[p] && rdy_s[p];
            free_s[p]     = (OW+1)'(DEPTH) - {1'b0, occ_s[p]} + {{OW{1'b0}}, pop_s[p]};
            arb_s[p]      = arb_e'({cand_a_s[p], cand_b_s[p]});
            wr0_en_s[p]   = 1'b0;
            wr1_en_s[p]   = 1'b0;
            wr0_data_s[p] = a;
            wr1_data_s[p] = b;
            drop_a_s[p]   = 1'b0;
            drop_b_s[p]   = 1'b0;
            case (arb_s[p])
                ARB_BOTH: begin
                    wr0_data_s[p] = a_wins_s ? a : b;
                    wr1_data_s[p] = a_wins_s ? bump_b_s : bump_a_s;
                    if (free_s[p] >= (OW+1)'(2)) begin
                        wr0_en_s[p] = 1'b1;
                        wr1_en_s[p] = 1'b1;
                    end else if (free_s[p] == (OW+1)'(1)) begin
                        wr0_en_s[p] = 1'b1;
                        drop_a_s[p] = !a_wins_s;
                        drop_b_s[p] = a_wins_s;
                    end else begin
                        drop_a_s[p] = 1'b1;
                        drop_b_s[p] = 1'b1;
                    end
                end
                ARB_A_ONLY: begin
                    wr0_data_s[p] = a;
                    if (free_s[p] != {(OW+1){1'b0}}) begin
                        wr0_en_s[p] = 1'b1;
                    end else begin
                        drop_a_s[p] = 1'b1;
                    end
                end
                ARB_B_ONLY: begin
                    wr0_data_s[p] = b;
                    if (free_s[p] != {(OW+1){1'b0}}) begin
                        wr0_en_s[p] = 1'b1;
                    end else begin
                        drop_b_s[p] = 1'b1;
                    end
                end
                default: begin
                    wr0_en_s[p] = 1'b0;
                end
            endcase
        end
    end

    // Drop reporting: each input reaches at most one port, so OR across ports is exact.
    always_comb begin
        drop_vec_s = {N{1'b0}};
        for (int c = 0; c < N; c++) begin
            drop_vec_s[c] = ((|drop_a_s) && (core_a_s == CW'(c))) ||
                            ((|drop_b_s) && (core_b_s == CW'(c)));
        end
        n_drop_s  = {1'b0, |drop_a_s} + {1'b0, |drop_b_s};
        cnt_sum_s = {1'b0, drop_cnt_r} + {15'd0, n_drop_s};
    end

    // Status registers: one-cycle drop pulse, collision flag, saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped_r  <= {N{1'b0}};
            coll_r     <= 1'b0;
            drop_cnt_r <= 16'd0;
        end else begin
            dropped_r  <= drop_vec_s;
            coll_r     <= va && vb && (sel_a == sel_b);
            drop_cnt_r <= (cnt_sum_s > 17'h0FFFF) ? 16'hFFFF : cnt_sum_s[15:0];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        switch_port_fifo #(
            .W     (WIR_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .wr0_en   (wr0_en_s[p]),
            .wr0_data (wr0_data_s[p]),
            .wr1_en   (wr1_en_s[p]),
            .wr1_data (wr1_data_s[p]),
            .rd_en    (pop_s[p]),
            .head     (head_s[p]),
            .valid    (valid_s[p]),
            .occ      (occ_s[p])
        );
    end

    assign y0                  = head_s[0];
    assign y1                  = head_s[1];
    assign v0                  = valid_s[0];
    assign v1                  = valid_s[1];
    assign occ0                = occ_s[0];
    assign occ1                = occ_s[1];
    assign dropped_core_vector = dropped_r;
    assign collision_detected  = coll_r;
    assign drop_cnt            = drop_cnt_r;

endmodule

// File: tb/tb_switch2x2_queued.sv
// Randomised bench for switch2x2_queued: a queue-based reference model predicts
// every output-queue head and the drop/collision status; a monitor compares.
module tb_switch2x2_queued;
    import switch2x2_queued_pkg::*;

    localparam int W     = `PACKET_W;
    localparam int DEPTH = 4;
    localparam int NC    = `N;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a = '0, b = '0;
    logic          va = 1'b0, vb = 1'b0, sel_a = 1'b0, sel_b = 1'b0;
    logic          rdy0 = 1'b0, rdy1 = 1'b0;
    logic [W-1:0]  y0, y1;
    logic          v0, v1;
    logic [OW-1:0] occ0, occ1;
    logic [NC-1:0] dropped_core_vector;
    logic          collision_detected;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    switch2x2_queued #(.WIR_W(W), .DEPTH(DEPTH), .N(NC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .a                   (a),
        .b                   (b),
        .va                  (va),
        .vb                  (vb),
        .sel_a               (sel_a),
        .sel_b               (sel_b),
        .rdy0                (rdy0),
        .rdy1                (rdy1),
        .y0                  (y0),
        .y1                  (y1),
        .v0                  (v0),
        .v1                  (v1),
        .occ0                (occ0),
        .occ1                (occ1),
        .dropped_core_vector (dropped_core_vector),
        .collision_detected  (collision_detected),
        .drop_cnt            (drop_cnt)
    );

    typedef struct {
        logic [NC-1:0] dcv;
        logic          coll;
        logic [15:0]   cnt;
    } side_t;

    logic [W-1:0] mq0 [$];
    logic [W-1:0] mq1 [$];
    side_t        side_q [$];
    int           pre_size [2];
    int           model_cnt = 0;
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int pri, input int core, input int pay);
        logic [W-1:0] p;
        p = W'(pay & 32'h7FF);
        p[`PKT_PRI_MSB:`PKT_PRI_LSB]   = 2'(pri);
        p[`PKT_CORE_MSB:`PKT_CORE_LSB] = 3'(core);
        return p;
    endfunction

    function automatic int pri_of(input logic [W-1:0] p);
        return int'(p[`PKT_PRI_MSB:`PKT_PRI_LSB]);
    endfunction

    function automatic int core_of(input logic [W-1:0] p);
        return int'(p[`PKT_CORE_MSB:`PKT_CORE_LSB]);
    endfunction

    function automatic logic [W-1:0] bumped(input logic [W-1:0] p);
        logic [W-1:0] r;
        int pr;
        r  = p;
        pr = pri_of(p) + 1;
        if (pr > 3) pr = 3;
        r[`PKT_PRI_MSB:`PKT_PRI_LSB] = 2'(pr);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_pkt();
        return mk(int'($urandom_range(0, 3)), int'($urandom_range(0, NC - 1)),
                  int'($urandom_range(0, 2047)));
    endfunction

    // Drive one cycle of stimulus and predict its effect on the queues and status outputs.
    task automatic step(input logic s_rst, input logic s_va, input logic [W-1:0] s_a, input logic s_sa,
                        input logic s_vb, input logic [W-1:0] s_b, input logic s_sb,
                        input logic s_r0, input logic s_r1);
        side_t        s;
        logic [W-1:0] cand [$];
        int           free;
        logic         r;
        @(negedge clk);
        #1;
        rst = s_rst; va = s_va; a = s_a; sel_a = s_sa;
        vb = s_vb; b = s_b; sel_b = s_sb; rdy0 = s_r0; rdy1 = s_r1;
        cyc++;
        pre_size[0] = mq0.size();
        pre_size[1] = mq1.size();
        s.dcv  = '0;
        s.coll = 1'b0;
        if (s_rst) begin
            model_cnt = 0;
        end else begin
            s.coll = s_va && s_vb && (s_sa == s_sb);
            for (int p = 0; p < 2; p++) begin
                cand = {};
                r = (p == 0) ? s_r0 : s_r1;
                if (s_va && s_vb && s_sa == p[0] && s_sb == p[0]) begin
                    if (pri_of(s_b) > pri_of(s_a)) begin
                        cand.push_back(s_b);
                        cand.push_back(bumped(s_a));
                    end else begin
                        cand.push_back(s_a);
                        cand.push_back(bumped(s_b));
                    end
                end else begin
                    if (s_va && s_sa == p[0]) cand.push_back(s_a);
                    if (s_vb && s_sb == p[0]) cand.push_back(s_b);
                end
                free = DEPTH - pre_size[p] + ((pre_size[p] > 0 && r) ? 1 : 0);
                foreach (cand[i]) begin
                    if (i < free) begin
                        if (p == 0) mq0.push_back(cand[i]);
                        else        mq1.push_back(cand[i]);
                    end else begin
                        s.dcv[core_of(cand[i])] = 1'b1;
                        model_cnt = (model_cnt >= 65535) ? 65535 : model_cnt + 1;
                    end
                end
            end
        end
        s.cnt = 16'(model_cnt);
        side_q.push_back(s);
    endtask

    task automatic idle(input int n, input logic r0, input logic r1);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, r0, r1);
    endtask

    // Monitor: compare queue heads, occupancy and status against the model each cycle.
    initial begin : monitor
        logic         ev0, ev1;
        logic [W-1:0] ey0, ey1;
        side_t        s;
        forever begin
            @(negedge clk);
            #2;
            if (cyc >= 2) begin
                ev0 = (pre_size[0] != 0);
                ev1 = (pre_size[1] != 0);
                ey0 = ev0 ? mq0[0] : '0;
                ey1 = ev1 ? mq1[0] : '0;
                chk("v0", 32'(v0), 32'(ev0));
                chk("v1", 32'(v1), 32'(ev1));
                chk("occ0", 32'(occ0), 32'(pre_size[0]));
                chk("occ1", 32'(occ1), 32'(pre_size[1]));
                chk("y0", 32'(y0), 32'(ey0));
                chk("y1", 32'(y1), 32'(ey1));
                if (rst) begin
                    mq0.delete();
                    mq1.delete();
                end else begin
                    if (ev0 && rdy0) void'(mq0.pop_front());
                    if (ev1 && rdy1) void'(mq1.pop_front());
                end
            end
            if (side_q.size() >= 2) begin
                s = side_q.pop_front();
                chk("dropped_core_vector", 32'(dropped_core_vector), 32'(s.dcv));
                chk("collision_detected", 32'(collision_detected), 32'(s.coll));
                chk("drop_cnt", 32'(drop_cnt), 32'(s.cnt));
            end
        end
    end

    initial begin : stimulus
        int pr;
        // Reset with both inputs valid: nothing may be enqueued or counted.
        step(1'b1, 1'b1, mk(1, 1, 11), 1'b0, 1'b1, mk(2, 2, 22), 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, mk(1, 1, 12), 1'b0, 1'b1, mk(2, 2, 23), 1'b0, 1'b1, 1'b1);
        // Different ports, no interaction.
        step(1'b0, 1'b1, mk(1, 1, 33), 1'b0, 1'b1, mk(0, 2, 44), 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);
        // Same port, b has higher priority: b first, then a bumped to 2.
        step(1'b0, 1'b1, mk(1, 3, 55), 1'b0, 1'b1, mk(2, 4, 66), 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);
        // Fill queue 0 to 3, then tie on one free slot: a kept, b (core 5) dropped.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, mk(0, i, 100 + i), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, mk(2, 1, 200), 1'b0, 1'b1, mk(2, 5, 201), 1'b0, 1'b0, 1'b1);
        // Full queue with a pop in the same cycle still accepts one packet.
        step(1'b0, 1'b1, mk(1, 6, 300), 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        // Back-pressure on port 1 for five cycles while port 0 keeps flowing.
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(3, 7, 400), 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, rnd_pkt(), 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(6, 1'b1, 1'b1);
        // Random traffic at low, medium and high downstream readiness, one mid-run reset.
        for (int ph = 0; ph < 3; ph++) begin
            pr = (ph == 0) ? 20 : ((ph == 1) ? 60 : 95);
            for (int i = 0; i < 600; i++) begin
                step((ph == 1 && i == 300) ? 1'b1 : 1'b0,
                     1'($urandom_range(0, 99) < 75), rnd_pkt(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) < 75), rnd_pkt(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 99) < pr));
            end
        end
        idle(12, 1'b1, 1'b1);
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
